// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one multiply-accumulate datapath between NUM_REQ FIR requesters.
// Define MAC_SATURATE_EN to saturate each product and accumulate step instead of wrapping.
module fir_mac_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op_valid,
  input  logic [NUM_REQ-1:0]            op_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_rd_en,
  output logic                          busy
);

  // state  | meaning
  // IDLE   | no grant; arbitrate among pending requests
  // MAC    | grantee streams operand pairs into the accumulator
  // RESULT | result held on out_* until the consumer reads it

  typedef enum logic [1:0] {IDLE, MAC, RESULT} state_t;

  localparam logic signed [2*DATA_WIDTH-1:0] BIAS_NEG =
    (2*DATA_WIDTH)'((longint'(1) << QUANT_BITS) - 1);
  localparam logic signed [2*DATA_WIDTH-1:0] BIAS_POS = '0;

  state_t state, state_next;

  logic [ID_WIDTH-1:0]            gidx, ptr, sel_idx;
  logic                           sel_found;
  logic [ID_WIDTH:0]              cand;
  logic signed [DATA_WIDTH-1:0]   acc, acc_sum, term, a_sel, b_sel;
  logic signed [2*DATA_WIDTH-1:0] prod, bias;
  logic                           start, take_pair, finish, abort_burst, accept;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] x);
    return (x == ID_WIDTH'(NUM_REQ - 1)) ? '0 : x + ID_WIDTH'(1);
  endfunction

  // first pending request at or above the pointer, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ)) cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      if (!sel_found && req[cand[ID_WIDTH-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  assign a_sel = op_a[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign b_sel = op_b[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign prod  = (2*DATA_WIDTH)'(a_sel) * (2*DATA_WIDTH)'(b_sel);
  // biasing negative products before the shift gives truncation toward zero
  assign bias  = prod[2*DATA_WIDTH-1] ? BIAS_NEG : BIAS_POS;

`ifdef MAC_SATURATE_EN
  localparam logic signed [2*DATA_WIDTH-1:0] Q_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [2*DATA_WIDTH-1:0] Q_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0]   S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0]   S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH:0]            sum_w;

  assign quot = (prod + bias) >>> QUANT_BITS;

  always_comb begin
    if (quot > Q_MAX)      term = S_MAX;
    else if (quot < Q_MIN) term = S_MIN;
    else                   term = quot[DATA_WIDTH-1:0];
    sum_w = {acc[DATA_WIDTH-1], acc} + {term[DATA_WIDTH-1], term};
    if (sum_w[DATA_WIDTH] != sum_w[DATA_WIDTH-1]) acc_sum = sum_w[DATA_WIDTH] ? S_MIN : S_MAX;
    else                                          acc_sum = sum_w[DATA_WIDTH-1:0];
  end
`else
  assign term    = DATA_WIDTH'((prod + bias) >>> QUANT_BITS);
  assign acc_sum = acc + term;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    take_pair   = 1'b0;
    finish      = 1'b0;
    abort_burst = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          start      = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        take_pair = op_valid[gidx];
        // a last pair arriving with req low still completes the burst
        if (op_valid[gidx] && op_last[gidx]) begin
          finish     = 1'b1;
          state_next = RESULT;
        end else if (!req[gidx]) begin
          abort_burst = 1'b1;
          state_next  = IDLE;
        end
      end
      RESULT: begin
        if (out_rd_en) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (start) begin
        grant <= NUM_REQ'(1) << sel_idx;
        gidx  <= sel_idx;
      end
      if (finish || abort_burst) grant <= '0;
      if (abort_burst || accept) acc <= '0;
      else if (take_pair)        acc <= acc_sum;
      if (abort_burst) ptr <= wrap_inc(gidx);
      if (accept) begin
        ptr       <= wrap_inc(out_id);
        out_valid <= 1'b0;
      end
      if (finish) begin
        out_valid <= 1'b1;
        out_data  <= acc_sum;
        out_id    <= gidx;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Round-robin scheduler that shares one multiply-accumulate datapath between up to NUM_REQ FIR-style requesters, such as the I/Q channel filters and the demod/audio filters.
- A granted requester streams tap/sample operand pairs for one dot product.
- The block dequantizes each product, accumulates, and returns the tagged result over a valid/rd_en output handshake.
- Removes per-filter multiplier arrays at the cost of serialised MAC time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, operand, accumulator and result width (signed two's complement)
QUANT_BITS, 10, fixed-point fraction bits; each product is divided by 2^QUANT_BITS
ID_WIDTH, $clog2(NUM_REQ), width of the result tag

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
req  in  NUM_REQ  per-requester request; must stay high until its burst ends
op_valid  in  NUM_REQ  per-requester operand pair valid
op_last  in  NUM_REQ  marks final operand pair of a burst (qualified by op_valid)
op_a  in  NUM_REQ*DATA_WIDTH  packed tap operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
op_b  in  NUM_REQ*DATA_WIDTH  packed sample operands, same packing
grant  out  NUM_REQ  one-hot grant, registered
out_valid  out  1  result available
out_data  out  DATA_WIDTH  accumulated dot product
out_id  out  ID_WIDTH  index of the requester that produced out_data
out_rd_en  in  1  consumer accepts the result when high with out_valid
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- grant=0, out_valid=0, out_data=0, out_id=0, busy=0.
- Accumulator=0, priority pointer=0, state=IDLE.

State machine (IDLE, MAC, RESULT):
- IDLE: if any req bit is set, select the first set bit scanning from the pointer upward with wrap. Register grant one-hot for the selection and go to MAC. If no req, stay in IDLE. Latency: req seen in IDLE at cycle n -> grant high at cycle n+1.
- MAC: each cycle with op_valid[g] high, where g is the grantee:
  - acc <= acc + trunc_DW(signed(op_a[g]) * signed(op_b[g]) / 2^QUANT_BITS).
  - The product is computed at full 2*DATA_WIDTH, then divided with truncation toward zero (not an arithmetic shift).
  - The add wraps modulo 2^DATA_WIDTH.
  - Cycles without op_valid are idle; no timeout.
  - op_valid/op_last from non-granted requesters are ignored.
- MAC, last pair: when op_valid[g] and op_last[g] are both high, include that pair and then go to RESULT:
  - out_valid=1 on the next cycle.
  - out_data is the final accumulator value.
  - out_id=g.
  - grant drops to 0 on the same edge.
- MAC, abort: if req[g] falls without a completed last pair, discard the accumulator (clear to 0), produce no result, set grant=0, advance pointer to g+1 mod NUM_REQ, and go to IDLE. If req falls and op_valid&op_last arrive in the same cycle, the last pair wins and the result is produced.
- RESULT: hold out_valid, out_data and out_id stable until out_rd_en=1. On that edge:
  - out_valid=0 and accumulator cleared;
  - pointer <= out_id+1 mod NUM_REQ;
  - go to IDLE.
  - Earliest next grant is 2 cycles after acceptance.
- Single-pair burst (op_last on the first op_valid) is legal: result = that one dequantized product.
- Fairness: a requester holding req continuously is granted at most once per NUM_REQ bursts while others request.
- Asynchronous reset mid-burst or mid-RESULT returns every register to its reset value; the pending result is lost.

Optional Feature:
Macro: MAC_SATURATE_EN.
- Defined: each accumulate step saturates to signed DATA_WIDTH limits (max 2^(DW-1)-1, min -2^(DW-1)) on overflow. The dequantized product itself is also clamped before the add. The clamped value persists and later terms add to it.
- Not defined: plain modulo-2^DATA_WIDTH wraparound, as in MAC.

Test Plan:
1. req[0] only; pairs (2048,1536),(1024,-1024),(512,512) last on 3rd -> grant=0001 one cycle after req; out_valid with out_data=3072-1024+256=2304, out_id=0.
2. req=1111 held, each burst 1 pair (1024,1024), out_rd_en=1 -> out_id sequence 0,1,2,3,0; each out_data=1024.
3. req[2] burst, drop req[2] after 2 pairs without op_last -> no out_valid, grant=0, next arbitration starts at requester 3.
4. Result pending with out_rd_en=0 for 10 cycles while req[1] high -> out_data/out_id stable, grant stays 0, grant[1] rises 2 cycles after out_rd_en=1.
5. Pairs (32'h7FFFFFFF,2048) twice, last on 2nd -> with MAC_SATURATE_EN out_data=32'h7FFFFFFF; without it, out_data = wrapped modulo-2^32 sum.
6. Drive reset=0 during MAC after 2 pairs -> grant=0, busy=0, out_valid=0 immediately; after release, a fresh 1-pair burst returns only that product.
